// File: rtl/sdram_resp_checker.sv
// Checks SDRAM read-response bursts against an incrementing pattern and reports the run result.
// Optional first-mismatch capture is enabled with macro SDRAM_RESP_CHECKER_FIRST_ERR_EN.
module sdram_resp_checker #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk_axi,
    input  logic              rst_axi,
    input  logic              start_i,
    input  logic [DATA_W-1:0] pattern_base_i,
    input  logic [CNT_W-1:0]  num_bursts_i,
    input  logic              resp_valid_i,
    input  logic              resp_last_i,
    input  logic [DATA_W-1:0] resp_data_i,
    output logic              resp_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [CNT_W-1:0]  err_count_o,
    output logic              err_last_o,
    output logic              stray_o,
    output logic [CNT_W-1:0]  first_err_beat_o,
    output logic [DATA_W-1:0] first_err_data_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  burst_q, burst_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]  gbeat_q, gbeat_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic              err_last_q, err_last_d;
    logic              stray_q, stray_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [DATA_W-1:0] exp_data;
    logic              mismatch;

    assign exp_data = base_q + DATA_W'(gbeat_q);
    assign mismatch = (resp_data_i != exp_data);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        burst_d    = burst_q;
        beat_d     = beat_q;
        gbeat_d    = gbeat_q;
        err_d      = err_q;
        err_last_d = err_last_q;
        stray_d    = stray_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                // start_i takes priority over a stray beat landing in the same cycle
                if (start_i) begin
                    base_d     = pattern_base_i;
                    num_d      = num_bursts_i;
                    burst_d    = '0;
                    beat_d     = '0;
                    gbeat_d    = '0;
                    err_d      = '0;
                    err_last_d = 1'b0;
                    stray_d    = 1'b0;
                    if (num_bursts_i == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_CHECK;
                    end
                end else if (resp_valid_i) begin
                    stray_d = 1'b1;
                end
            end
            S_CHECK: begin
                if (resp_valid_i) begin
                    gbeat_d = gbeat_q + 1'b1;
                    if (mismatch && (err_q != '1)) begin
                        err_d = err_q + 1'b1;
                    end
                    if (resp_last_i) begin
                        if (beat_q != LAST_BEAT) begin
                            err_last_d = 1'b1;
                        end
                        beat_d  = '0;
                        burst_d = burst_q + 1'b1;
                        if (burst_d == num_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end else if (beat_q == LAST_BEAT) begin
                        // Missing last: flag it and hold the beat counter at the burst end
                        err_last_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        pass_d = (state_d == S_DONE) && (err_d == '0) && !err_last_d && !stray_d;
    end

    always_ff @(posedge clk_axi) begin
        if (rst_axi) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            num_q      <= '0;
            burst_q    <= '0;
            beat_q     <= '0;
            gbeat_q    <= '0;
            err_q      <= '0;
            err_last_q <= 1'b0;
            stray_q    <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            burst_q    <= burst_d;
            beat_q     <= beat_d;
            gbeat_q    <= gbeat_d;
            err_q      <= err_d;
            err_last_q <= err_last_d;
            stray_q    <= stray_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

`ifdef SDRAM_RESP_CHECKER_FIRST_ERR_EN
    logic [CNT_W-1:0]  first_beat_q, first_beat_d;
    logic [DATA_W-1:0] first_data_q, first_data_d;

    always_comb begin
        first_beat_d = first_beat_q;
        first_data_d = first_data_q;
        if ((state_q != S_CHECK) && start_i) begin
            first_beat_d = '0;
            first_data_d = '0;
        end else if ((state_q == S_CHECK) && resp_valid_i && mismatch && (err_q == '0)) begin
            first_beat_d = gbeat_q;
            first_data_d = resp_data_i;
        end
    end

    always_ff @(posedge clk_axi) begin
        if (rst_axi) begin
            first_beat_q <= '0;
            first_data_q <= '0;
        end else begin
            first_beat_q <= first_beat_d;
            first_data_q <= first_data_d;
        end
    end

    assign first_err_beat_o = first_beat_q;
    assign first_err_data_o = first_data_q;
`else
    assign first_err_beat_o = '0;
    assign first_err_data_o = '0;
`endif

    assign resp_ready_o = 1'b1;
    assign busy_o       = (state_q == S_CHECK);
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign err_count_o  = err_q;
    assign err_last_o   = err_last_q;
    assign stray_o      = stray_q;

endmodule

// File: doc/sdram_resp_checker.md
SDRAM_RESP_CHECKER -- requirements
Module: sdram_resp_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of the response data and pattern.
REQ-002 SHALL have parameter BURST_LEN, default 8, number of beats per read burst (2..256).
REQ-003 SHALL have parameter CNT_W, default 16, width of the burst, beat and error counters.
REQ-004 SHALL have port clk_axi  in  1  single clock; all logic is in this domain.
REQ-005 SHALL have port rst_axi  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start_i  in  1  arm the check run; pattern_base_i and num_bursts_i sampled on this cycle.
REQ-007 SHALL have port pattern_base_i  in  DATA_W  expected value of the first beat.
REQ-008 SHALL have port num_bursts_i  in  CNT_W  bursts to check in this run.
REQ-009 SHALL have port resp_valid_i  in  1  response beat valid from the SDRAM driver.
REQ-010 SHALL have port resp_last_i  in  1  final beat of a burst.
REQ-011 SHALL have port resp_data_i  in  DATA_W  response data.
REQ-012 SHALL have port resp_ready_o  out  1  beat accept.
REQ-013 SHALL have port busy_o  out  1  run in progress.
REQ-014 SHALL have port done_o  out  1  one-cycle pulse at run end.
REQ-015 SHALL have port pass_o  out  1  run result, valid while in DONE.
REQ-016 SHALL have port err_count_o  out  CNT_W  data-mismatch count, saturating.
REQ-017 SHALL have port err_last_o  out  1  sticky: resp_last misplaced.
REQ-018 SHALL have port stray_o  out  1  sticky: beat accepted outside a run.
REQ-019 SHALL have ports first_err_beat_o (out, CNT_W) and first_err_data_o (out, DATA_W), which report the first mismatch.

Function
REQ-020 SHALL implement states IDLE, CHECK and DONE.
REQ-021 SHALL define a beat as accepted when resp_valid_i && resp_ready_o on a rising clk_axi edge.
REQ-022 SHALL hold resp_ready_o at 1 in every state, so the block never stalls the driver.
REQ-023 IDLE/DONE + start_i with num_bursts_i != 0 SHALL move to CHECK next cycle and clear err_count_o, err_last_o, stray_o and all counters.
REQ-024 IDLE/DONE + start_i with num_bursts_i == 0 SHALL move directly to DONE, pulse done_o and set pass_o=1.
REQ-025 In CHECK, start_i SHALL be ignored.
REQ-026 In CHECK, expected data SHALL equal pattern_base + global beat index, computed modulo 2^DATA_W (wrap-around required).
REQ-027 An accepted beat whose data differs from expected SHALL increment err_count_o in the same cycle, saturating at 2^CNT_W-1.
REQ-028 The beat-in-burst counter SHALL reset to 0 on every accepted resp_last_i, and otherwise increment on every accepted beat.
REQ-029 The burst counter SHALL increment on every accepted resp_last_i.
REQ-030 err_last_o SHALL set when resp_last_i is accepted with beat-in-burst != BURST_LEN-1, or when it is absent with beat-in-burst == BURST_LEN-1; the beat counter never advances past BURST_LEN-1 without a resp_last_i.
REQ-031 The accepted resp_last_i that brings the burst count to num_bursts SHALL cause a move to DONE next cycle, with done_o high for exactly that one cycle.
REQ-032 pass_o SHALL equal (err_count_o==0 && !err_last_o && !stray_o) while in DONE, and SHALL be 0 elsewhere.
REQ-033 Beats accepted in IDLE or DONE SHALL set stray_o and SHALL NOT be checked.
REQ-034 busy_o SHALL be 1 in CHECK only.
REQ-035 All outputs SHALL be registered, with no combinational path from resp_* to any output except resp_ready_o (which is constant 1).

Reset
REQ-036 rst_axi SHALL force IDLE, busy_o=0, done_o=0, pass_o=0, err_count_o=0, err_last_o=0, stray_o=0, first_err_*=0 and all counters to 0.
REQ-037 rst_axi asserted mid-CHECK SHALL abort the run without a done_o pulse; beats arriving in the reset cycle SHALL be ignored.

Configuration
REQ-038 With macro SDRAM_RESP_CHECKER_FIRST_ERR_EN defined, first_err_beat_o and first_err_data_o SHALL capture the global beat index and received data of the first mismatch in a run, hold them until the next start_i, and be cleared by start_i.
REQ-039 Without SDRAM_RESP_CHECKER_FIRST_ERR_EN, both ports SHALL remain present and be driven constant 0, with no capture registers synthesized.

Verification
REQ-040 base=0x1000, num_bursts=4, BURST_LEN=8, correct data 0x1000..0x101F with last on every 8th beat -> done_o pulses once, pass_o=1, err_count_o=0.
REQ-041 Same run with beat 11 corrupted to 0xDEAD -> err_count_o=1, pass_o=0, and (macro on) first_err_beat_o=11, first_err_data_o=0xDEAD.
REQ-042 base=0xFFFC, num_bursts=1, data 0xFFFC..0x0003 -> pass_o=1 (wrap-around).
REQ-043 resp_last_i asserted on beat 5 of burst 0 -> err_last_o=1, the next burst is counted from beat 0, and pass_o=0.
REQ-044 A beat in IDLE, then start_i with num_bursts=0 -> stray_o cleared by start_i, done_o pulses next cycle, pass_o=1.
REQ-045 rst_axi asserted after 3 beats of a run -> IDLE, no done_o pulse, all counters 0; a fresh run afterwards passes.
